// File: rtl/radiometer_sequencer_if.sv
// ADC conversion handshake and UART transmit handshake seen by the radiometer sequencer.
// The sequencer is the master: it requests conversions and offers results for transmission.
interface radiometer_sequencer_if #(
    parameter int unsigned DATA_W = 12
) ();
    logic              adc_start;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              tx_start;
    logic              tx_busy;
    logic [DATA_W-1:0] tx_data;

    modport master (
        output adc_start,
        output tx_start,
        output tx_data,
        input  adc_valid,
        input  adc_data,
        input  tx_busy
    );

    modport slave (
        input  adc_start,
        input  tx_start,
        input  tx_data,
        output adc_valid,
        output adc_data,
        output tx_busy
    );
endinterface

// File: rtl/radiometer_sequencer.sv
// Dicke-switched radiometer frame controller: settle, acquire signal and ground phases,
// average each, and transmit the clamped difference over a start/busy handshake.
module radiometer_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned SAMPLES_LOG2  = 4,
    parameter int unsigned DATA_W        = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    radiometer_sequencer_if.master        bus,
    output logic                          switch_sel,
    output logic [3:0]                    state_dbg
);
    localparam int unsigned AccW = DATA_W + SAMPLES_LOG2;
    localparam int unsigned CntW = SAMPLES_LOG2 + 1;
    localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CntW-1:0] NumSamples = CntW'(1) << SAMPLES_LOG2;
    localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYCLES - 1);

    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StSetSig    = 4'd1;
    localparam logic [3:0] StSettleSig = 4'd2;
    localparam logic [3:0] StAcqSig    = 4'd3;
    localparam logic [3:0] StSetGnd    = 4'd4;
    localparam logic [3:0] StSettleGnd = 4'd5;
    localparam logic [3:0] StAcqGnd    = 4'd6;
    localparam logic [3:0] StCompute   = 4'd7;
    localparam logic [3:0] StSend      = 4'd8;
    localparam logic [3:0] StWaitTx    = 4'd9;

    logic [3:0]        state_q, state_d;
    logic              switch_q, switch_d;
    logic              adc_start_q, adc_start_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [AccW-1:0]   acc_sig_q, acc_sig_d;
    logic [AccW-1:0]   acc_gnd_q, acc_gnd_d;
    logic [3:0]        wait_q, wait_d;
    logic              seen_busy_q, seen_busy_d;

    logic [CntW-1:0]   count_inc;
    logic [AccW-1:0]   sample_ext;
    logic [DATA_W-1:0] avg_sig, avg_gnd;
    logic              tx_done;

    assign count_inc  = count_q + CntW'(1);
    assign sample_ext = AccW'(bus.adc_data);
    assign avg_sig    = DATA_W'(acc_sig_q >> SAMPLES_LOG2);
    assign avg_gnd    = DATA_W'(acc_gnd_q >> SAMPLES_LOG2);

    always_comb begin
        state_d     = state_q;
        switch_d    = switch_q;
        adc_start_d = 1'b0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        settle_d    = settle_q;
        count_d     = count_q;
        acc_sig_d   = acc_sig_q;
        acc_gnd_d   = acc_gnd_q;
        wait_d      = wait_q;
        seen_busy_d = seen_busy_q;
        tx_done     = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable) state_d = StSetSig;
            end
            StSetSig: begin
                switch_d  = 1'b1;
                acc_sig_d = '0;
                count_d   = '0;
                settle_d  = SettleLoad;
                state_d   = StSettleSig;
            end
            StSettleSig: begin
                if (settle_q == '0) begin
                    adc_start_d = 1'b1;
                    state_d     = StAcqSig;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StAcqSig: begin
                if (bus.adc_valid) begin
                    acc_sig_d = acc_sig_q + sample_ext;
                    count_d   = count_inc;
                    if (count_inc == NumSamples) state_d = StSetGnd;
                    else adc_start_d = 1'b1;
                end
            end
            StSetGnd: begin
                switch_d  = 1'b0;
                acc_gnd_d = '0;
                count_d   = '0;
                settle_d  = SettleLoad;
                state_d   = StSettleGnd;
            end
            StSettleGnd: begin
                if (settle_q == '0) begin
                    adc_start_d = 1'b1;
                    state_d     = StAcqGnd;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StAcqGnd: begin
                if (bus.adc_valid) begin
                    acc_gnd_d = acc_gnd_q + sample_ext;
                    count_d   = count_inc;
                    if (count_inc == NumSamples) state_d = StCompute;
                    else adc_start_d = 1'b1;
                end
            end
            StCompute: begin
                tx_data_d = (avg_sig >= avg_gnd) ? (avg_sig - avg_gnd) : '0;
                state_d   = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    tx_start_d  = 1'b1;
                    wait_d      = '0;
                    seen_busy_d = 1'b0;
                    state_d     = StWaitTx;
                end
            end
            StWaitTx: begin
                // A transmitter that never raises busy is treated as done after 16 cycles.
                if (seen_busy_q) begin
                    if (!bus.tx_busy) tx_done = 1'b1;
                end else if (bus.tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (wait_q == 4'd15) begin
                    tx_done = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
                if (tx_done) state_d = enable ? StSetSig : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Losing enable before the result is offered abandons the frame; tx_data is kept.
        if (!enable && state_q >= StSetSig && state_q <= StCompute) begin
            state_d     = StIdle;
            switch_d    = 1'b0;
            adc_start_d = 1'b0;
            tx_data_d   = tx_data_q;
            count_d     = '0;
            acc_sig_d   = '0;
            acc_gnd_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            switch_q    <= 1'b0;
            adc_start_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            settle_q    <= '0;
            count_q     <= '0;
            acc_sig_q   <= '0;
            acc_gnd_q   <= '0;
            wait_q      <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            switch_q    <= switch_d;
            adc_start_q <= adc_start_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            settle_q    <= settle_d;
            count_q     <= count_d;
            acc_sig_q   <= acc_sig_d;
            acc_gnd_q   <= acc_gnd_d;
            wait_q      <= wait_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    assign bus.adc_start = adc_start_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign switch_sel    = switch_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_radiometer_sequencer.sv
// Randomized bench for radiometer_sequencer: ADC and UART behavioural models plus a
// frame-level reference computing the clamped average difference from the sample sets.
module tb_radiometer_sequencer;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned LOG2   = 2;
    localparam int          N      = 4;
    localparam int unsigned DW     = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       switch_sel;
    logic [3:0] state_dbg;

    radiometer_sequencer_if #(.DATA_W(DW)) bus ();

    radiometer_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .SAMPLES_LOG2 (LOG2),
        .DATA_W       (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bus       (bus),
        .switch_sel(switch_sel),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ADC model state
    int sig_s[N];
    int gnd_s[N];
    int idx_sig, idx_gnd;
    int latency = 3;
    int lat_cnt = 0;
    logic req_phase;
    int overlap = 0;
    bit inject_stray = 0;

    // Frame monitor state
    int   starts_sig, starts_gnd;
    int   settle_meas[2];
    int   settle_cnt;
    bit   settle_run = 0;
    logic prev_sw = 1'b0;
    int   tx_cnt = 0;
    int   last_tx = 0;

    // UART model state
    bit force_busy = 0;
    bit uart_silent = 0;
    bit uart_busy = 0;
    int uart_delay = 0;
    int busy_left = 0;

    assign bus.tx_busy = force_busy | uart_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_diff();
        int ss = 0;
        int gs = 0;
        for (int i = 0; i < N; i++) begin
            ss += sig_s[i];
            gs += gnd_s[i];
        end
        ss = ss / N;
        gs = gs / N;
        return (ss >= gs) ? ss - gs : 0;
    endfunction

    initial begin : models
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        forever begin
            @(negedge clk);
            if (switch_sel !== prev_sw) begin
                settle_run = 1;
                settle_cnt = 0;
                prev_sw    = switch_sel;
            end
            if (settle_run) begin
                if (bus.adc_start) begin
                    settle_meas[switch_sel] = settle_cnt;
                    settle_run = 0;
                end else begin
                    settle_cnt++;
                end
            end

            bus.adc_valid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.adc_valid = 1'b1;
                    if (req_phase) begin
                        bus.adc_data = DW'(sig_s[idx_sig % N]);
                        idx_sig++;
                    end else begin
                        bus.adc_data = DW'(gnd_s[idx_gnd % N]);
                        idx_gnd++;
                    end
                end
            end
            if (bus.adc_start) begin
                if (lat_cnt > 0) overlap++;
                lat_cnt   = latency;
                req_phase = switch_sel;
                if (switch_sel) starts_sig++;
                else starts_gnd++;
            end
            if (inject_stray) begin
                bus.adc_valid = 1'b1;
                bus.adc_data  = 12'hFFF;
            end

            if (uart_delay > 0) begin
                uart_delay--;
                if (uart_delay == 0) busy_left = 6;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (bus.tx_start) begin
                tx_cnt++;
                last_tx = int'(bus.tx_data);
                if (!uart_silent) uart_delay = 2;
            end
            uart_busy = (busy_left > 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int maxc, input string tag);
        for (int i = 0; i < maxc && state_dbg !== s; i++) tick(1);
        check(tag, 32'(state_dbg), 32'(s));
    endtask

    task automatic wait_tx(input int prev, input int maxc, input string tag);
        for (int i = 0; i < maxc && tx_cnt == prev; i++) tick(1);
        check(tag, tx_cnt, prev + 1);
    endtask

    task automatic start_frame();
        idx_sig = 0;
        idx_gnd = 0;
        starts_sig = 0;
        starts_gnd = 0;
        settle_meas[0] = -1;
        settle_meas[1] = -1;
        enable = 1'b1;
    endtask

    task automatic run_frame(input string tag);
        int prev;
        prev = tx_cnt;
        start_frame();
        wait_tx(prev, 400, {tag, "_tx_start"});
        enable = 1'b0;
        check({tag, "_tx_data"}, last_tx, ref_diff());
        check({tag, "_sig_requests"}, starts_sig, N);
        check({tag, "_gnd_requests"}, starts_gnd, N);
        check({tag, "_sig_settle"}, settle_meas[1], SETTLE);
        check({tag, "_gnd_settle"}, settle_meas[0], SETTLE);
        wait_state(4'd0, 60, {tag, "_idle"});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin : main
        int prev, saved, c, bad;
        bit rose, fell;
        reset  = 1'b1;
        enable = 1'b0;
        #1 reset = 1'b0;
        tick(2);
        check("rst_state", 32'(state_dbg), 0);
        check("rst_switch", 32'(switch_sel), 0);
        check("rst_adc_start", 32'(bus.adc_start), 0);
        check("rst_tx_start", 32'(bus.tx_start), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        reset = 1'b1;
        tick(2);

        sig_s = '{2000, 2000, 2000, 2000};
        gnd_s = '{1000, 1000, 1000, 1000};
        latency = 3;
        run_frame("nominal");

        sig_s = '{100, 101, 102, 103};
        gnd_s = '{200, 200, 200, 200};
        run_frame("clamp");

        sig_s = '{4095, 4095, 4095, 4095};
        gnd_s = '{0, 0, 0, 0};
        run_frame("fullscale");

        for (int f = 0; f < 5; f++) begin
            latency = int'($urandom_range(1, 4));
            for (int i = 0; i < N; i++) begin
                sig_s[i] = int'($urandom_range(0, 4095));
                gnd_s[i] = int'($urandom_range(0, 4095));
            end
            run_frame("random");
        end

        // Busy held while the result is ready, enable kept high across frames
        latency = 2;
        sig_s = '{3000, 3000, 3000, 3000};
        gnd_s = '{500, 500, 500, 500};
        force_busy = 1;
        prev = tx_cnt;
        start_frame();
        wait_state(4'd8, 400, "busy_reach_send");
        tick(20);
        check("busy_hold_no_start", tx_cnt, prev);
        force_busy = 0;
        tick(1);
        check("busy_drop_start", 32'(bus.tx_start), 1);
        check("busy_drop_count", tx_cnt, prev + 1);
        check("busy_tx_data", last_tx, ref_diff());
        rose = 0;
        fell = 0;
        bad  = 0;
        for (int i = 0; i < 40 && !fell; i++) begin
            tick(1);
            if (state_dbg !== 4'd9) bad++;
            if (bus.tx_busy) rose = 1;
            else if (rose) fell = 1;
        end
        check("busy_wait_holds", bad, 0);
        check("busy_rise_fall_seen", 32'(fell), 1);
        wait_state(4'd1, 4, "busy_next_frame");
        enable = 1'b0;
        wait_state(4'd0, 10, "busy_abort_idle");

        // Transmitter that never raises busy
        uart_silent = 1;
        sig_s = '{1500, 1600, 1700, 1800};
        gnd_s = '{100, 200, 300, 400};
        prev = tx_cnt;
        start_frame();
        wait_tx(prev, 400, "silent_tx_start");
        enable = 1'b0;
        check("silent_tx_data", last_tx, ref_diff());
        c = 0;
        while (state_dbg !== 4'd0 && c < 40) begin
            tick(1);
            c++;
        end
        check("silent_timeout_window", 32'(c >= 14 && c <= 18), 1);
        uart_silent = 0;

        // Abort during ground acquisition
        saved = last_tx;
        sig_s = '{1234, 1234, 1234, 1234};
        gnd_s = '{4000, 4000, 4000, 4000};
        start_frame();
        wait_state(4'd6, 400, "abort_reach_acq_gnd");
        enable = 1'b0;
        prev = tx_cnt;
        tick(1);
        check("abort_state", 32'(state_dbg), 0);
        check("abort_switch", 32'(switch_sel), 0);
        tick(30);
        check("abort_no_tx", tx_cnt, prev);
        check("abort_tx_data_kept", 32'(bus.tx_data), saved);
        sig_s = '{3000, 3001, 3002, 3003};
        gnd_s = '{1, 1, 1, 1};
        run_frame("after_abort");

        // Asynchronous reset while settling
        start_frame();
        wait_state(4'd2, 50, "rst_reach_settle");
        #2 reset = 1'b0;
        enable = 1'b0;
        #1;
        check("async_rst_state", 32'(state_dbg), 0);
        check("async_rst_switch", 32'(switch_sel), 0);
        check("async_rst_adc_start", 32'(bus.adc_start), 0);
        check("async_rst_tx_start", 32'(bus.tx_start), 0);
        check("async_rst_tx_data", 32'(bus.tx_data), 0);
        tick(2);
        reset = 1'b1;
        prev = tx_cnt;
        tick(1);
        inject_stray = 1;
        tick(1);
        inject_stray = 0;
        tick(3);
        check("stray_state", 32'(state_dbg), 0);
        check("stray_no_tx", tx_cnt, prev);
        check("stray_tx_data", 32'(bus.tx_data), 0);
        sig_s = '{800, 810, 820, 830};
        gnd_s = '{300, 301, 302, 303};
        run_frame("after_reset");

        check("single_outstanding", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/radiometer_sequencer.md
Name: radiometer_sequencer

Overview:
- Frame-level controller for the 22 GHz radiometer back end.
- Drives the Dicke switch select, waits for the front end to settle, then requests 2^SAMPLES_LOG2 ADC conversions per phase (signal, then ground).
- Averages each phase and forms the clamped difference avg_sig − avg_gnd.
- Hands the 12-bit result to the UART transmitter with a start/busy handshake, then repeats while enabled.

Parameters:
- SETTLE_CYCLES, 1000: clk cycles to wait after every switch_sel change before the first conversion request; legal range ≥ 1.
- SAMPLES_LOG2, 4: log2 of conversions averaged per phase (16); legal range 0..8.
- DATA_W, 12: ADC sample width and tx_data width.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; synchronous level.
- adc_valid  in  1  one-cycle strobe; adc_data is valid in the same cycle.
- adc_data  in  DATA_W  conversion result, unsigned.
- tx_busy  in  1  UART transmitter busy.
- switch_sel  out  1  0 = ground/reference feed, 1 = antenna/signal feed.
- adc_start  out  1  one-cycle conversion request.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  DATA_W  difference result; held stable from tx_start until the next COMPUTE.
- state_dbg  out  4  current state encoding; drives LED[3:0].

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - switch_sel, adc_start, tx_start = 0.
  - tx_data = 0; accumulators and counters = 0.
  - state_dbg = 0.
- All outputs are registered.
- State encoding and transitions:
  - IDLE (0): if enable=1, go to SET_SIG.
  - SET_SIG (1): switch_sel←1; clear acc and sample count; load settle counter with SETTLE_CYCLES−1; go to SETTLE_SIG.
  - SETTLE_SIG (2): decrement the settle counter each cycle; at 0, pulse adc_start for one cycle and go to ACQ_SIG.
  - ACQ_SIG (3):
    - On adc_valid: acc_sig += adc_data, count++.
    - If count reaches 2^SAMPLES_LOG2, go to SET_GND.
    - Otherwise pulse adc_start in the cycle after adc_valid.
    - Exactly one outstanding request at any time.
  - SET_GND (4): switch_sel←0; clear count; reload the settle counter; go to SETTLE_GND.
  - SETTLE_GND (5): same as SETTLE_SIG, then go to ACQ_GND.
  - ACQ_GND (6): same as ACQ_SIG, accumulating into acc_gnd; when complete go to COMPUTE.
  - COMPUTE (7):
    - avg_x = acc_x >> SAMPLES_LOG2, truncating.
    - tx_data ← avg_sig − avg_gnd if avg_sig ≥ avg_gnd, else 0 (clamp, no wrap).
    - Go to SEND.
  - SEND (8): when tx_busy=0, pulse tx_start for one cycle and go to WAIT_TX. While tx_busy=1, stay in SEND.
  - WAIT_TX (9):
    - Wait for tx_busy=1, then tx_busy=0.
    - Then go to SET_SIG if enable=1, else IDLE.
    - If tx_busy never rises within 16 cycles of tx_start, treat the transfer as complete.
- Arithmetic: accumulators are DATA_W+SAMPLES_LOG2 bits, so a full-scale average cannot overflow.
- Boundary conditions:
  - adc_valid outside ACQ_SIG/ACQ_GND: ignored.
  - adc_valid in the same cycle as adc_start: accepted; it counts as the response to the prior request.
  - enable=0 in states 1–7: abort next cycle to IDLE; switch_sel←0; accumulators cleared; no transmission; tx_data keeps its last value.
  - enable=0 in SEND or WAIT_TX: the in-flight transfer completes, then the block goes to IDLE.
  - Asynchronous reset mid-frame: immediate return to reset values; no tx_start may be issued in the reset-release cycle.
  - SAMPLES_LOG2=0: exactly one conversion per phase.
- Throughput with defaults: about 2·(1000+16·T_adc) cycles plus UART time per frame.

Test Plan:
- SETTLE_CYCLES=4, SAMPLES_LOG2=2, enable=1, ADC model returns 2000 on signal and 1000 on ground, latency 3:
  - switch_sel=1 for 4 settle cycles, then 4 adc_start pulses.
  - switch_sel=0, 4 settle cycles, 4 pulses.
  - tx_data=1000 with one tx_start.
- Signal samples 100,101,102,103 (avg 101) and ground 200 (avg 200) → tx_data=0 (clamped).
- Signal samples 4095×4 and ground 0×4 → tx_data=4095; no overflow.
- Hold tx_busy=1 while entering SEND for 20 cycles → tx_start stays 0; it asserts exactly once in the cycle tx_busy drops; the next frame starts only after busy rises and falls.
- Drop enable during ACQ_GND → next state IDLE, switch_sel=0, no tx_start. Re-raise enable → a fresh frame with cleared accumulators produces the correct average.
- Assert reset=0 asynchronously mid-SETTLE_SIG, and inject adc_valid in IDLE → all outputs are 0 immediately and the stray adc_valid changes nothing.
